// File: rtl/board_click_ctrl_if.sv
// ---------------------------------------------------------------------------
// board_click_ctrl_if
//   Groups the click controller's handshake/bus signals towards the game logic.
//
//   place_valid : one-cycle pulse carrying a placement click
//   place_cor   : placement coordinate {col[7:4], row[3:0]}, valid with place_valid
//   shot_valid  : a shot request is pending
//   shot_cor    : shot coordinate {col[7:4], row[3:0]}, held while shot_valid
//   shot_ready  : game logic accepts the pending shot
//
//   master : the click controller (drives place/shot, samples shot_ready)
//   slave  : the game logic
// ---------------------------------------------------------------------------
interface board_click_ctrl_if;
    logic       place_valid;
    logic [7:0] place_cor;
    logic       shot_valid;
    logic [7:0] shot_cor;
    logic       shot_ready;

    modport master (
        output place_valid,
        output place_cor,
        output shot_valid,
        output shot_cor,
        input  shot_ready
    );

    modport slave (
        input  place_valid,
        input  place_cor,
        input  shot_valid,
        input  shot_cor,
        output shot_ready
    );
endinterface

// File: rtl/board_click_ctrl.sv
// ---------------------------------------------------------------------------
// board_click_ctrl
//   Turns raw mouse clicks into placement events and shot requests for a
//   battleship-style game. A click is a rising edge of `left`; one press
//   produces at most one event. Shots use a valid/ready handshake.
//
//   Optional feature (macro SHOT_MAP_EN): a BOARD_DIM x BOARD_DIM map of
//   cells already shot; a fire click on such a cell pulses dup_pulse instead
//   of issuing a shot. A start_btn rising edge clears the map. Without the
//   macro there is no map and dup_pulse is tied low.
//
//   Parameter BOARD_DIM : valid cells per axis (nibble valid when < BOARD_DIM)
//
//   Ports:
//     clk         : system clock, rising edge
//     rst         : asynchronous active-low reset
//     left        : raw left mouse button level
//     start_btn   : registered start button level
//     player_cor  : {col,row} on player board, 8'hff = off board
//     enemy_cor   : {col,row} on enemy board,  8'hff = off board
//     place_en    : ship-placement phase active
//     fire_en     : player's turn to shoot
//     bus         : master side of board_click_ctrl_if (place/shot handshake)
//     start_pulse : one-cycle pulse on each start_btn rising edge
//     dup_pulse   : one-cycle pulse when a click on an already-shot cell is rejected
// ---------------------------------------------------------------------------
module board_click_ctrl #(
    parameter int BOARD_DIM = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      left,
    input  logic                      start_btn,
    input  logic [7:0]                player_cor,
    input  logic [7:0]                enemy_cor,
    input  logic                      place_en,
    input  logic                      fire_en,
    board_click_ctrl_if.master        bus,
    output logic                      start_pulse,
    output logic                      dup_pulse
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    localparam logic [4:0] DIM = 5'(BOARD_DIM);

    logic [1:0] state;
    logic       left_q;
    logic       start_q;

    logic       place_valid_q;
    logic [7:0] place_cor_q;
    logic       shot_valid_q;
    logic [7:0] shot_cor_q;

    logic       click;
    logic       start_rise;
    logic       player_ok;
    logic       enemy_ok;
    logic       place_go;
    logic       fire_go;
    logic       accept;
    logic       dup_hit;

    function automatic logic cor_ok(input logic [7:0] c);
        return ({1'b0, c[7:4]} < DIM) && ({1'b0, c[3:0]} < DIM);
    endfunction

    assign click      = left & ~left_q;
    assign start_rise = start_btn & ~start_q;
    assign player_ok  = cor_ok(player_cor);
    assign enemy_ok   = cor_ok(enemy_cor);

    // Placement has priority: with place_en high a click never becomes a shot.
    assign place_go = (state == IDLE) && click && place_en && player_ok;
    assign fire_go  = (state == IDLE) && click && !place_en && fire_en && enemy_ok;
    assign accept   = (state == REQ) && shot_valid_q && bus.shot_ready;

    // Input history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            left_q  <= left;
            start_q <= start_btn;
        end
    end

    // Start pulse runs independently of the FSM state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= start_rise;
        end
    end

    // Click FSM and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            place_valid_q <= 1'b0;
            place_cor_q   <= '1;
            shot_valid_q  <= 1'b0;
            shot_cor_q    <= '1;
        end else begin
            place_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (place_go) begin
                        place_valid_q <= 1'b1;
                        place_cor_q   <= player_cor;
                        state         <= WAIT_REL;
                    end else if (fire_go) begin
                        if (dup_hit) begin
                            state <= WAIT_REL;
                        end else begin
                            shot_cor_q   <= enemy_cor;
                            shot_valid_q <= 1'b1;
                            state        <= REQ;
                        end
                    end
                end
                // Request is held regardless of fire_en or further clicks.
                REQ: begin
                    if (accept) begin
                        shot_valid_q <= 1'b0;
                        state        <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!left) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHOT_MAP_EN
    localparam int unsigned MAP_BITS = BOARD_DIM * BOARD_DIM;
    localparam int unsigned IDX_W    = $clog2(MAP_BITS);

    logic [MAP_BITS-1:0] shot_map;
    logic [IDX_W-1:0]    enemy_idx;
    logic [IDX_W-1:0]    shot_idx;

    assign enemy_idx = IDX_W'(enemy_cor[3:0] * BOARD_DIM + enemy_cor[7:4]);
    assign shot_idx  = IDX_W'(shot_cor_q[3:0] * BOARD_DIM + shot_cor_q[7:4]);
    assign dup_hit   = shot_map[enemy_idx];

    // Clear has priority over marking an accepted shot in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shot_map <= '0;
        end else if (start_pulse) begin
            shot_map <= '0;
        end else if (accept) begin
            shot_map[shot_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dup_pulse <= 1'b0;
        end else begin
            dup_pulse <= fire_go & dup_hit;
        end
    end
`else
    assign dup_hit   = 1'b0;
    assign dup_pulse = 1'b0;
`endif

    assign bus.place_valid = place_valid_q;
    assign bus.place_cor   = place_cor_q;
    assign bus.shot_valid  = shot_valid_q;
    assign bus.shot_cor    = shot_cor_q;

endmodule

// File: doc/board_click_ctrl.md
BOARD_CLICK_CTRL -- requirements
Module: board_click_ctrl

Interface
REQ-001 The block SHALL have parameter BOARD_DIM, default 10, giving the number of valid cells per board axis; a nibble is valid when it is less than BOARD_DIM.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port left, input, 1 bit: raw left mouse button level.
REQ-005 The block SHALL have port start_btn, input, 1 bit: registered level, high while the start button is pressed.
REQ-006 The block SHALL have port player_cor, input, 8 bits: {col[7:4], row[3:0]} on the player board; 8'hff means outside the board.
REQ-007 The block SHALL have port enemy_cor, input, 8 bits: {col[7:4], row[3:0]} on the enemy board; 8'hff means outside the board.
REQ-008 The block SHALL have port place_en, input, 1 bit: ship-placement phase is active.
REQ-009 The block SHALL have port fire_en, input, 1 bit: it is the player's turn to shoot.
REQ-010 The block SHALL have port shot_ready, input, 1 bit: the game logic accepts the pending shot.
REQ-011 The block SHALL have port start_pulse, output, 1 bit: one-cycle pulse when a start press is detected.
REQ-012 The block SHALL have port place_valid, output, 1 bit: one-cycle pulse carrying a placement click.
REQ-013 The block SHALL have port place_cor, output, 8 bits: placement coordinate, valid with place_valid.
REQ-014 The block SHALL have port shot_valid, output, 1 bit: a shot request is pending.
REQ-015 The block SHALL have port shot_cor, output, 8 bits: shot coordinate, held while shot_valid is high.
REQ-016 The block SHALL have port dup_pulse, output, 1 bit: one-cycle pulse when a click on an already-shot cell is rejected.

Function
REQ-017 All outputs SHALL be registered; each output pulse SHALL appear one cycle after the triggering input edge.
REQ-018 The block SHALL register left and start_btn; a click is defined as left high in the current cycle and low in the previous cycle.
REQ-019 start_pulse SHALL assert for exactly one cycle on each rising edge of start_btn, in every state; asserting start_pulse SHALL clear the shot map.
REQ-020 The FSM SHALL have three states: IDLE, REQ and WAIT_REL.
REQ-021 In IDLE, a click with place_en=1 and both player_cor nibbles valid SHALL pulse place_valid for one cycle with place_cor equal to the player_cor sampled at the click; the FSM SHALL then go to WAIT_REL.
REQ-022 In IDLE, a click with place_en=0, fire_en=1, both enemy_cor nibbles valid and the target cell not yet shot SHALL capture enemy_cor into shot_cor, assert shot_valid and go to REQ.
REQ-023 Click priority SHALL be placement over shot; when both place_en and fire_en are high, no shot SHALL be issued.
REQ-024 An invalid coordinate, including 8'hff or any nibble >= BOARD_DIM, SHALL produce no output; the FSM SHALL remain in IDLE.
REQ-025 In REQ, shot_valid and shot_cor SHALL stay constant until shot_ready=1 is sampled while shot_valid=1; the request SHALL NOT be withdrawn if fire_en drops.
REQ-026 On acceptance, the next cycle SHALL deassert shot_valid, set the map bit for the shot cell, and move the FSM to WAIT_REL.
REQ-027 In REQ, further clicks SHALL be ignored.
REQ-028 WAIT_REL SHALL return to IDLE in the cycle after left is sampled low, so that one press produces at most one event.
REQ-029 The shot map SHALL be BOARD_DIM x BOARD_DIM bits, indexed as row*BOARD_DIM + col.
REQ-030 If a shot_ready acceptance and a start_pulse occur in the same cycle, the clear SHALL win and the map SHALL end up all zero.

Reset
REQ-031 While rst=0, the FSM SHALL be in IDLE; start_pulse, place_valid, shot_valid and dup_pulse SHALL be 0; place_cor and shot_cor SHALL be 8'hff; the left and start_btn history registers SHALL be 0; the map SHALL be cleared.
REQ-032 A reset asserted during REQ SHALL drop the pending shot immediately, without waiting for a clock edge.

Configuration
REQ-033 The macro SHOT_MAP_EN SHALL control the duplicate-shot map.
REQ-034 With SHOT_MAP_EN defined, the block SHALL implement the shot map; a fire click on an already-set cell SHALL pulse dup_pulse for one cycle, issue no shot, and move the FSM to WAIT_REL.
REQ-035 With SHOT_MAP_EN undefined, the block SHALL contain no map storage, every valid fire click SHALL issue a shot, and dup_pulse SHALL be constant 0.

Verification
REQ-036 Scenario: place_en=1, player_cor=8'h23, left 0->1 -> place_valid=1 for exactly one cycle with place_cor=8'h23; holding left produces no second pulse.
REQ-037 Scenario: fire_en=1, enemy_cor=8'h45, click, shot_ready held low for 5 cycles, then high for 1 cycle -> shot_valid high for 6 cycles with shot_cor=8'h45, low on the next cycle.
REQ-038 Scenario: enemy_cor=8'hff, and separately enemy_cor=8'hA0 with BOARD_DIM=10, each clicked with fire_en=1 -> no shot_valid, no place_valid, FSM stays in IDLE.
REQ-039 Scenario (SHOT_MAP_EN defined): shot at 8'h45 accepted, release, click 8'h45 again -> dup_pulse=1 for one cycle, shot_valid stays 0; after a start_btn rising edge, clicking 8'h45 -> shot issued.
REQ-040 Scenario: rst driven to 0 mid-REQ without a clock edge -> shot_valid=0 and shot_cor=8'hff immediately; after release, the FSM is in IDLE.
REQ-041 Scenario: start_btn 0->1 while in REQ -> start_pulse for one cycle, the pending shot is kept, and the map is cleared.
